flush_ctrl: RTL
===============

FLUSH_CTRL -- requirements
Module: flush_ctrl

Interface
REQ-001 SHALL have parameter OSTD_W, default 3, meaning the width of the outstanding instruction-request counter.
REQ-002 SHALL have parameter MAX_OSTD, default 4, meaning the maximum number of outstanding instruction requests; it SHALL be no greater than 2^OSTD_W-1.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ws_ex  input  1  exception commit from writeback; already qualified with writeback valid.
REQ-006 SHALL have port ws_ertn  input  1  ertn commit from writeback; already qualified with writeback valid.
REQ-007 SHALL have port ex_entry  input  32  exception entry PC from the CSR file.
REQ-008 SHALL have port ex_era  input  32  exception return address from the CSR file.
REQ-009 SHALL have port inst_req_hs  input  1  instruction-bus request handshake (req & addr_ok).
REQ-010 SHALL have port inst_resp_hs  input  1  instruction-bus response handshake (data_ok).
REQ-011 SHALL have port fs_redirect_ack  input  1  fetch stage has accepted redirect_pc.
REQ-012 SHALL have port flush_out  output  1  one-cycle pulse that invalidates every pipeline stage.
REQ-013 SHALL have port req_block  output  1  fetch stage SHALL issue no new instruction request while this is high.
REQ-014 SHALL have port fs_discard  output  1  the current instruction response belongs to a flushed request and SHALL be dropped.
REQ-015 SHALL have port redirect_valid  output  1  redirect_pc is valid for fetch.
REQ-016 SHALL have port redirect_pc  output  32  PC at which fetch restarts.
REQ-017 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 SHALL keep an outstanding counter ostd: +1 on inst_req_hs only, -1 on inst_resp_hs only, unchanged on both or neither.
REQ-019 SHALL hold ostd at MAX_OSTD on inst_req_hs alone when already full (no wrap), and hold it at 0 on inst_resp_hs alone when empty.
REQ-020 SHALL implement the FSM states IDLE, DRAIN and REDIRECT.
REQ-021 SHALL define event = ws_ex | ws_ertn, and SHALL sample it only in IDLE; events in DRAIN or REDIRECT are ignored.
REQ-022 SHALL, on an event in IDLE, latch the target: ex_entry if ws_ex is high (ws_ex takes priority when both are high), else ex_era.
REQ-023 SHALL, on an event in IDLE, move to DRAIN when the next-cycle ostd value is nonzero, and otherwise move directly to REDIRECT.
REQ-024 SHALL register flush_out so it is high for exactly the one cycle following the event edge.
REQ-025 SHALL drive req_block combinationally high when event is high in IDLE, and high in DRAIN and REDIRECT.
REQ-026 SHALL drive fs_discard high in DRAIN only.
REQ-027 SHALL, in DRAIN, move to REDIRECT on the edge at which ostd becomes 0.
REQ-028 SHALL drive redirect_valid = (state==REDIRECT) and redirect_pc = latched target; redirect_pc SHALL be stable while redirect_valid is high.
REQ-029 SHALL, in REDIRECT, return to IDLE on the edge at which fs_redirect_ack is high; redirect_valid SHALL be low the next cycle.
REQ-030 SHALL give a minimum latency from event to redirect_valid of 1 cycle (ostd=0) and SHALL never reach REDIRECT while ostd>0.
REQ-031 SHALL accept a new event in the cycle immediately after returning to IDLE.

Reset
REQ-032 SHALL, while resetn is low, asynchronously force state=IDLE, ostd=0, target=0, flush_out=0, req_block=0, fs_discard=0, redirect_valid=0, redirect_pc=0 and busy=0.
REQ-033 SHALL, if reset is asserted mid-drain or mid-redirect, abandon the redirect with no pulse on deassertion.

Verification
REQ-034 SHALL cover: ostd=0, ws_ex=1, ex_entry=0x1C008000 -> flush_out pulse next cycle, redirect_valid=1 with redirect_pc=0x1C008000; ack -> IDLE.
REQ-035 SHALL cover: ostd=2, ws_ertn=1, ex_era=0x1C000100 -> DRAIN with fs_discard=1 over two responses; after the second response, redirect_pc=0x1C000100.
REQ-036 SHALL cover: ws_ex=1 and ws_ertn=1 in the same cycle -> redirect_pc=ex_entry.
REQ-037 SHALL cover: ws_ex pulse during REDIRECT with a different ex_entry -> ignored; redirect_pc unchanged and no second flush_out.
REQ-038 SHALL cover: inst_req_hs and inst_resp_hs together on the event edge with ostd=1 -> DRAIN, and one further response reaches REDIRECT.
REQ-039 SHALL cover: resetn driven low asynchronously while in DRAIN -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/flush_ctrl.sv
// flush_ctrl: pipeline flush and fetch redirect on exception or ertn commit.
// It counts outstanding instruction requests. When a flush event arrives it
// blocks new fetches and discards responses still in flight. Once the bus is
// quiet, it offers the restart PC to fetch.
//
// Handshake semantics: redirect_valid/fs_redirect_ack follow strict
// valid/ready rules. redirect_valid rises without waiting for ack.
// redirect_pc is held constant while redirect_valid is high. The transfer
// completes on the rising clk edge where both are high. The bus handshakes
// inst_req_hs/inst_resp_hs arrive as already-completed transfers (one per
// cycle when high).
module flush_ctrl #(
  parameter int OSTD_W   = 3,
  parameter int MAX_OSTD = 4   // must not exceed 2**OSTD_W - 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_ex,
  input  logic        ws_ertn,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ex_era,
  input  logic        inst_req_hs,
  input  logic        inst_resp_hs,
  input  logic        fs_redirect_ack,
  output logic        flush_out,
  output logic        req_block,
  output logic        fs_discard,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [OSTD_W-1:0]   ostd, ostd_nxt;
  logic [31:0]         target, target_nxt;
  logic                flush_evt;
  logic                take_evt;

  assign flush_evt = ws_ex | ws_ertn;
  // Events are only honoured in IDLE; later ones belong to squashed instructions.
  assign take_evt  = (state == IDLE) && flush_evt;

  // Next outstanding count: saturate at both ends, simultaneous req+resp cancel.
  always_comb begin
    ostd_nxt = ostd;
    if (inst_req_hs && !inst_resp_hs) begin
      if (ostd != OSTD_W'(MAX_OSTD)) ostd_nxt = ostd + 1'b1;
    end else if (inst_resp_hs && !inst_req_hs) begin
      if (ostd != '0) ostd_nxt = ostd - 1'b1;
    end
  end

  // Next-state and target selection; ws_ex wins over ws_ertn.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    case (state)
      IDLE: begin
        if (flush_evt) begin
          target_nxt = ws_ex ? ex_entry : ex_era;
          state_nxt  = (ostd_nxt != '0) ? DRAIN : REDIRECT;
        end
      end
      DRAIN: begin
        if (ostd_nxt == '0) state_nxt = REDIRECT;
      end
      REDIRECT: begin
        if (fs_redirect_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter, target and the registered flush pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      ostd      <= '0;
      target    <= '0;
      flush_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      ostd      <= ostd_nxt;
      target    <= target_nxt;
      flush_out <= take_evt;
    end
  end

  // Output decode. req_block is gated by resetn so that it also reads 0
  // while reset is held, even with an event input high.
  always_comb begin
    req_block      = resetn && (take_evt || (state != IDLE));
    fs_discard     = (state == DRAIN);
    redirect_valid = (state == REDIRECT);
    redirect_pc    = target;
    busy           = (state != IDLE);
    state_dbg      = state;
  end

endmodule
